// File: rtl/cpu_pkg.sv
// Shared decode constants: instruction field positions and widths for the CPU datapath.
package cpu_pkg;
    localparam int XLEN_DEF = 32;
    localparam int INSTR_W  = 32;
    localparam int OPC_W    = 7;
    localparam int IMM_W    = 15;
    localparam int OPC_LSB  = 25;
    localparam int RS_LSB   = 20;
    localparam int RT_LSB   = 15;
    localparam int RD_LSB   = 10;
    localparam int IMM_LSB  = 0;
endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write port,
// register 0 hard-wired to zero, asynchronous clear.
module reg_file
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_en,
    input  logic [RA_W-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [RA_W-1:0] rd_addr1,
    output logic [XLEN-1:0] rd_data1,
    input  logic [RA_W-1:0] rd_addr2,
    output logic [XLEN-1:0] rd_data2
);
    logic [XLEN-1:0] regs [NREGS];

    // Each register is its own flop bank so reset can clear the whole file at once.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_flop
                logic [XLEN-1:0] q_reg;
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        q_reg <= '0;
                    end else if (wr_en && (wr_addr == RA_W'(gi))) begin
                        q_reg <= wr_data;
                    end
                end
                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];
endmodule

// File: rtl/decode_stage_pipe.sv
// Instruction-decode pipeline stage: register file with write-back bypass,
// field slicing, and a registered valid/ready output with flush and held-bundle snooping.
module decode_stage_pipe
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [RA_W-1:0]    wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opcode,
    output logic [RA_W-1:0]    rs,
    output logic [RA_W-1:0]    rt,
    output logic [RA_W-1:0]    rd,
    output logic [XLEN-1:0]    readData1,
    output logic [XLEN-1:0]    readData2,
    output logic [XLEN-1:0]    signExtendedImmediate
);
    logic [RA_W-1:0]  rs_next, rt_next, rd_next;
    logic [OPC_W-1:0] opcode_next;
    logic [XLEN-1:0]  imm_next;
    logic [XLEN-1:0]  rf_data1, rf_data2;
    logic [XLEN-1:0]  read1_next, read2_next;
    logic             accept;
    logic             held;

    assign opcode_next = instruction[OPC_LSB +: OPC_W];
    assign rs_next     = instruction[RS_LSB +: RA_W];
    assign rt_next     = instruction[RT_LSB +: RA_W];
    assign rd_next     = instruction[RD_LSB +: RA_W];
    assign imm_next    = {{(XLEN-IMM_W){instruction[IMM_LSB+IMM_W-1]}}, instruction[IMM_LSB +: IMM_W]};

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .RA_W  (RA_W)
    ) u_reg_file (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rd_addr1 (rs_next),
        .rd_data1 (rf_data1),
        .rd_addr2 (rt_next),
        .rd_data2 (rf_data2)
    );

    // Same-cycle write-back wins over the array so write-then-read is coherent.
    assign read1_next = (rs_next == '0) ? '0 :
                        (wb_en && (wb_addr == rs_next)) ? wb_data : rf_data1;
    assign read2_next = (rt_next == '0) ? '0 :
                        (wb_en && (wb_addr == rt_next)) ? wb_data : rf_data2;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign held     = out_valid && !out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid             <= 1'b0;
            opcode                <= '0;
            rs                    <= '0;
            rt                    <= '0;
            rd                    <= '0;
            readData1             <= '0;
            readData2             <= '0;
            signExtendedImmediate <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid             <= 1'b1;
            opcode                <= opcode_next;
            rs                    <= rs_next;
            rt                    <= rt_next;
            rd                    <= rd_next;
            readData1             <= read1_next;
            readData2             <= read2_next;
            signExtendedImmediate <= imm_next;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A stalled bundle keeps its operands current with later write-backs.
            if (held && wb_en && (wb_addr != '0) && (wb_addr == rs)) begin
                readData1 <= wb_data;
            end
            if (held && wb_en && (wb_addr != '0) && (wb_addr == rt)) begin
                readData2 <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: field decode, bypass, r0, back-pressure/snoop, flush, async reset.
module tb_decode_stage_pipe;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [6:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [31:0] readData1, readData2, signExtendedImmediate;

    int checks = 0;
    int errors = 0;

    decode_stage_pipe dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .instruction           (instruction),
        .flush                 (flush),
        .wb_en                 (wb_en),
        .wb_addr               (wb_addr),
        .wb_data               (wb_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .opcode                (opcode),
        .rs                    (rs),
        .rt                    (rt),
        .rd                    (rd),
        .readData1             (readData1),
        .readData2             (readData2),
        .signExtendedImmediate (signExtendedImmediate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [14:0] low);
        return {op, a, b, low};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        $display("t=%0t out_valid=%0b in_ready=%0b opcode=%h rs=%0d rt=%0d rd=%0d rd1=%h rd2=%h imm=%h",
                 $time, out_valid, in_ready, opcode, rs, rt, rd, readData1, readData2, signExtendedImmediate);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_opcode", {25'd0, opcode}, 32'd0);
        check("rst_rd1", readData1, 32'd0);
        check("rst_imm", signExtendedImmediate, 32'd0);
        RST = 1'b0;

        // Field decode
        in_valid = 1'b1;
        instruction = 32'b01110111011101110111001101110111;
        step();
        check("dec_valid", {31'd0, out_valid}, 32'd1);
        check("dec_opcode", {25'd0, opcode}, 32'h3B);
        check("dec_rs", {27'd0, rs}, 32'd23);
        check("dec_rt", {27'd0, rt}, 32'd14);
        check("dec_rd", {27'd0, rd}, 32'd28);
        check("dec_imm", signExtendedImmediate, 32'hFFFFF377);
        check("dec_rd1", readData1, 32'd0);
        check("dec_rd2", readData2, 32'd0);

        // Same-cycle write-back bypass into rs=23
        wb_en = 1'b1; wb_addr = 5'd23; wb_data = 32'hDEADBEEF;
        step();
        check("byp_rd1", readData1, 32'hDEADBEEF);
        check("byp_rd2", readData2, 32'd0);

        // r0 write ignored and read as zero; rt=23 from array
        instruction = mk(7'h01, 5'd0, 5'd23, 15'h0000);
        wb_addr = 5'd0; wb_data = 32'h1234;
        step();
        check("r0_rd1", readData1, 32'd0);
        check("arr_rd2", readData2, 32'hDEADBEEF);
        check("r0_opcode", {25'd0, opcode}, 32'h01);
        wb_en = 1'b0;

        // Back-pressure: accept A, then stall with B waiting
        instruction = 32'b01110111011101110111001101110111;
        step();
        check("bp_a_rd1", readData1, 32'hDEADBEEF);
        out_ready = 1'b0;
        instruction = mk(7'h02, 5'd0, 5'd0, 15'h0410);
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        wb_en = 1'b1; wb_addr = 5'd14; wb_data = 32'h55;
        step();
        check("snoop_rd2", readData2, 32'h55);
        check("snoop_rd1", readData1, 32'hDEADBEEF);
        check("snoop_opcode", {25'd0, opcode}, 32'h3B);
        wb_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_opcode", {25'd0, opcode}, 32'h3B);
            check("hold_rd2", readData2, 32'h55);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("b_opcode", {25'd0, opcode}, 32'h02);
        check("b_rd", {27'd0, rd}, 32'd1);
        check("b_imm", signExtendedImmediate, 32'h0410);
        check("b_rd1_r0", readData1, 32'd0);
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("nodup_valid", {31'd0, out_valid}, 32'd0);

        // Flush a held bundle while a new instruction is offered
        in_valid = 1'b1;
        instruction = mk(7'h03, 5'd1, 5'd2, 15'h0000);
        step();
        check("c_opcode", {25'd0, opcode}, 32'h03);
        out_ready = 1'b0;
        flush = 1'b1;
        instruction = mk(7'h04, 5'd5, 5'd14, 15'h0000);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFE;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("flush_noacc_valid", {31'd0, out_valid}, 32'd0);
        check("flush_noacc_opc", {25'd0, opcode}, 32'h03);
        in_valid = 1'b1;
        instruction = mk(7'h05, 5'd5, 5'd14, 15'h7FFF);
        step();
        check("e_opcode", {25'd0, opcode}, 32'h05);
        check("e_wb_commit", readData1, 32'hCAFE);
        check("e_rd2", readData2, 32'h55);
        check("e_imm", signExtendedImmediate, 32'hFFFFFFFF);

        // Asynchronous reset between edges
        out_ready = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_opcode", {25'd0, opcode}, 32'd0);
        check("arst_rd1", readData1, 32'd0);
        check("arst_rd2", readData2, 32'd0);
        check("arst_imm", signExtendedImmediate, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        #1;
        RST = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_valid", {31'd0, out_valid}, 32'd1);
        check("post_opcode", {25'd0, opcode}, 32'h05);
        check("post_rs", {27'd0, rs}, 32'd5);
        check("post_rd1_clr", readData1, 32'd0);
        check("post_rd2_clr", readData2, 32'd0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
